spi_register_slave: RTL and testbench

SPI responder at the far end of the sensor register-configuration link: a behavioural and synthesizable register-file target that accepts the write/read frames issued by the FPGA-side SPI master. It serves as the bench model of the CMOS sensor's register bank and as a loop-back target on the board. It oversamples SCK, SS_N and MOSI in the system clock domain and shifts read data back on MISO.

---
 rtl/spi_reg_pkg.sv | 18 +
 rtl/spi_slave_sync.sv | 39 +++
 rtl/spi_register_slave.sv | 175 +++++++++++++++++
 tb/tb_spi_register_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI register-file responder.
// Frame layout: cmd, address, data, MSB first.
package spi_reg_pkg;
   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 16;
   localparam int FRAME_W = 1 + ADDR_W + DATA_W;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_HOLD
   } state_t;
endpackage

// File: rtl/spi_slave_sync.sv
// Brings SS_N, SCK and MOSI into the system clock domain and
// produces single-cycle SCK rise/fall pulses.
module spi_slave_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ss_n,
   input  logic i_sck,
   input  logic i_mosi,
   output logic o_ss_n,
   output logic o_sck_rise,
   output logic o_sck_fall,
   output logic o_mosi
);
   logic [1:0] r_ss_n;
   logic [1:0] r_sck;
   logic [1:0] r_mosi;
   logic       r_sck_d;

   // SS_N resets to "selected" so a select held low across reset
   // never looks like a fresh falling edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ss_n  <= 2'b00;
         r_sck   <= 2'b00;
         r_mosi  <= 2'b00;
         r_sck_d <= 1'b0;
      end else begin
         r_ss_n  <= {r_ss_n[0], i_ss_n};
         r_sck   <= {r_sck[0], i_sck};
         r_mosi  <= {r_mosi[0], i_mosi};
         r_sck_d <= r_sck[1];
      end
   end

   assign o_ss_n     = r_ss_n[1];
   assign o_mosi     = r_mosi[1];
   assign o_sck_rise = r_sck[1] & ~r_sck_d;
   assign o_sck_fall = ~r_sck[1] & r_sck_d;
endmodule

// File: rtl/spi_register_slave.sv
// SPI mode-0 register-file target: 26-bit write/read frames,
// oversampled in the system clock domain.
module spi_register_slave
   import spi_reg_pkg::*;
#(
   parameter int DEPTH = 512
) (
   input  logic              sys_clk_50M,
   input  logic              sys_reset,
   input  logic              spi_ss_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_strobe,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              frame_err
);
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);
   localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);

   logic w_ss_n, w_rise, w_fall, w_mosi;

   spi_slave_sync u_sync (
      .i_clk      (sys_clk_50M),
      .i_rst      (sys_reset),
      .i_ss_n     (spi_ss_n),
      .i_sck      (spi_sck),
      .i_mosi     (spi_mosi),
      .o_ss_n     (w_ss_n),
      .o_sck_rise (w_rise),
      .o_sck_fall (w_fall),
      .o_mosi     (w_mosi)
   );

   state_t              r_state, w_state_nxt;
   logic                r_ss_prev;
   logic [4:0]          r_cnt;
   logic                r_cmd;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-2:0]   r_data;
   logic [DATA_W-1:0]   r_shift;
   logic                r_miso;
   logic                r_load;
   logic [DATA_W-1:0]   r_ram_q;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_ss_fall, w_in_range, w_last_data, w_we;
   logic [RAM_AW-1:0]   w_idx;
   logic [DATA_W-1:0]   w_wdata;

   assign w_ss_fall   = r_ss_prev & ~w_ss_n;
   assign w_in_range  = (32'(r_addr) < 32'(DEPTH));
   assign w_idx       = r_addr[RAM_AW-1:0];
   assign w_wdata     = {r_data, w_mosi};
   assign w_last_data = (r_state == ST_DATA) && !w_ss_n
                        && w_rise && (r_cnt == DATA_LAST);
   assign w_we        = !sys_reset && w_last_data
                        && (r_cmd == CMD_WRITE) && w_in_range;

   always_ff @(posedge sys_clk_50M) begin
      if (sys_reset) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // SS_N deassertion outranks a same-cycle SCK rise.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_ss_fall) w_state_nxt = ST_CMD;
         ST_CMD: begin
            if (w_ss_n)      w_state_nxt = ST_IDLE;
            else if (w_rise) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            if (w_ss_n) w_state_nxt = ST_IDLE;
            else if (w_rise && r_cnt == ADDR_LAST)
               w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_ss_n)           w_state_nxt = ST_IDLE;
            else if (w_last_data) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: if (w_ss_n) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      spi_miso_oe = 1'b0;
      spi_miso    = 1'b0;
      if (r_state == ST_DATA && r_cmd == CMD_READ) begin
         spi_miso_oe = 1'b1;
         spi_miso    = r_miso;
      end
   end

   always_ff @(posedge sys_clk_50M) begin
      if (w_we) r_mem[w_idx] <= w_wdata;
      r_ram_q <= r_mem[w_idx];
   end

   always_ff @(posedge sys_clk_50M) begin
      if (sys_reset) begin
         r_ss_prev <= 1'b0;
         r_cnt     <= '0;
         r_cmd     <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_shift   <= '0;
         r_miso    <= 1'b0;
         r_load    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_strobe <= 1'b0;
         rd_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         r_ss_prev <= w_ss_n;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         frame_err <= 1'b0;
         r_load    <= rd_strobe;
         if (r_state != ST_DATA) r_miso <= 1'b0;
         if (r_load) r_shift <= w_in_range ? r_ram_q : '0;
         if (w_we) begin
            wr_strobe <= 1'b1;
            wr_addr   <= r_addr;
            wr_data   <= w_wdata;
         end
         unique case (r_state)
            ST_IDLE: r_cnt <= '0;
            ST_CMD: begin
               if (w_ss_n) frame_err <= 1'b1;
               else if (w_rise) r_cmd <= w_mosi;
            end
            ST_ADDR: begin
               if (w_ss_n) frame_err <= 1'b1;
               else if (w_rise) begin
                  r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
                  if (r_cnt == ADDR_LAST) begin
                     r_cnt <= '0;
                     if (r_cmd == CMD_READ) begin
                        rd_strobe <= 1'b1;
                        rd_addr   <= {r_addr[ADDR_W-2:0], w_mosi};
                     end
                  end else begin
                     r_cnt <= r_cnt + 5'd1;
                  end
               end
            end
            ST_DATA: begin
               if (w_ss_n) frame_err <= 1'b1;
               else begin
                  if (w_rise) begin
                     r_data <= {r_data[DATA_W-3:0], w_mosi};
                     r_cnt  <= r_cnt + 5'd1;
                  end
                  if (w_fall && r_cmd == CMD_READ) begin
                     r_miso  <= r_shift[DATA_W-1];
                     r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                  end
               end
            end
            ST_HOLD: r_cnt <= '0;
            default: r_cnt <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_register_slave.sv
// Directed bench for spi_register_slave: write/read frames, out-of-range,
// aborted, over-long frames and reset during a read.
module tb_spi_register_slave;
   logic        sys_clk_50M = 1'b0;
   logic        sys_reset   = 1'b1;
   logic        spi_ss_n    = 1'b1;
   logic        spi_sck     = 1'b0;
   logic        spi_mosi    = 1'b0;
   logic        spi_miso, spi_miso_oe;
   logic        wr_strobe, rd_strobe, frame_err;
   logic [8:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;

   int n_checks = 0;
   int n_errors = 0;
   int n_wr = 0;
   int n_rd = 0;
   int n_fe = 0;

   spi_register_slave #(.DEPTH(256)) dut (
      .sys_clk_50M (sys_clk_50M),
      .sys_reset   (sys_reset),
      .spi_ss_n    (spi_ss_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_strobe   (rd_strobe),
      .rd_addr     (rd_addr),
      .frame_err   (frame_err)
   );

   always #10 sys_clk_50M = ~sys_clk_50M;

   always @(negedge sys_clk_50M) begin
      if (!sys_reset) begin
         if (wr_strobe) n_wr++;
         if (rd_strobe) n_rd++;
         if (frame_err) n_fe++;
      end
   end

   // SCK at 6.25 MHz: 80 ns low, 80 ns high; MISO sampled 20 ns after rise.
   task automatic spi_xfer(input logic cmd, input logic [8:0] addr,
                           input logic [15:0] data, input int nbits,
                           input bit keep_ss, output logic [15:0] rdat,
                           output int oe_bad, output int extra_bad);
      logic [25:0] fr;
      logic        exp_oe;
      fr = {cmd, addr, data};
      rdat = '0;
      oe_bad = 0;
      extra_bad = 0;
      spi_ss_n = 1'b0;
      #160;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 26) ? fr[25-i] : 1'b1;
         #80 spi_sck = 1'b1;
         #20;
         if (i >= 10 && i < 26) rdat = {rdat[14:0], spi_miso};
         exp_oe = (cmd == 1'b0) && (i >= 10) && (i < 26);
         if (spi_miso_oe !== exp_oe) oe_bad++;
         if (i >= 26 && (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0))
            extra_bad++;
         #60 spi_sck = 1'b0;
      end
      #80;
      if (!keep_ss) begin
         spi_ss_n = 1'b1;
         #300;
      end
   endtask

   task automatic test_reset;
      repeat (5) @(posedge sys_clk_50M);
      #1;
      n_checks++;
      if ({spi_miso, spi_miso_oe} !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_miso got %b%b want 00", spi_miso, spi_miso_oe);
      end
      n_checks++;
      if ({wr_strobe, rd_strobe, frame_err} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_strobes got %b%b%b want 000",
                  wr_strobe, rd_strobe, frame_err);
      end
      n_checks++;
      if (wr_addr !== 9'h000 || wr_data !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_wr got %h/%h want 000/0000", wr_addr, wr_data);
      end
      n_checks++;
      if (rd_addr !== 9'h000) begin
         n_errors++;
         $display("FAIL reset_rd_addr got %h want 000", rd_addr);
      end
      sys_reset = 1'b0;
      #200;
   endtask

   task automatic test_write;
      logic [15:0] rd;
      int ob, eb, w0, f0;
      w0 = n_wr; f0 = n_fe;
      spi_xfer(1'b1, 9'h012, 16'hA5C3, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (n_wr - w0 != 1) begin
         n_errors++;
         $display("FAIL write_count got %0d want 1", n_wr - w0);
      end
      n_checks++;
      if (wr_addr !== 9'h012 || wr_data !== 16'hA5C3) begin
         n_errors++;
         $display("FAIL write_value got %h/%h want 012/a5c3", wr_addr, wr_data);
      end
      n_checks++;
      if (n_fe != f0 || ob != 0) begin
         n_errors++;
         $display("FAIL write_err_oe got fe=%0d oe_bad=%0d want 0/0",
                  n_fe - f0, ob);
      end
   endtask

   task automatic test_read;
      logic [15:0] rd;
      int ob, eb, r0, w0;
      r0 = n_rd; w0 = n_wr;
      spi_xfer(1'b0, 9'h012, 16'h0000, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (n_rd - r0 != 1 || rd_addr !== 9'h012) begin
         n_errors++;
         $display("FAIL read_strobe got n=%0d addr=%h want 1/012",
                  n_rd - r0, rd_addr);
      end
      n_checks++;
      if (rd !== 16'hA5C3) begin
         n_errors++;
         $display("FAIL read_data got %h want a5c3", rd);
      end
      n_checks++;
      if (ob != 0) begin
         n_errors++;
         $display("FAIL read_oe got %0d bad samples want 0", ob);
      end
      n_checks++;
      if (n_wr != w0) begin
         n_errors++;
         $display("FAIL read_nowrite got %0d want 0", n_wr - w0);
      end
   endtask

   task automatic test_unimpl;
      logic [15:0] rd;
      int ob, eb, w0;
      w0 = n_wr;
      spi_xfer(1'b1, 9'h1FF, 16'hBEEF, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (n_wr != w0) begin
         n_errors++;
         $display("FAIL unimpl_write got %0d strobes want 0", n_wr - w0);
      end
      spi_xfer(1'b0, 9'h1FF, 16'h0000, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (rd !== 16'h0000 || rd_addr !== 9'h1FF) begin
         n_errors++;
         $display("FAIL unimpl_read got %h@%h want 0000@1ff", rd, rd_addr);
      end
   endtask

   task automatic test_abort;
      logic [15:0] rd;
      int ob, eb, w0, f0;
      spi_xfer(1'b1, 9'h005, 16'h1234, 26, 1'b0, rd, ob, eb);
      w0 = n_wr; f0 = n_fe;
      spi_xfer(1'b1, 9'h005, 16'hFFFF, 12, 1'b0, rd, ob, eb);
      n_checks++;
      if (n_fe - f0 != 1) begin
         n_errors++;
         $display("FAIL abort_frame_err got %0d want 1", n_fe - f0);
      end
      n_checks++;
      if (n_wr != w0) begin
         n_errors++;
         $display("FAIL abort_nowrite got %0d want 0", n_wr - w0);
      end
      spi_xfer(1'b0, 9'h005, 16'h0000, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (rd !== 16'h1234) begin
         n_errors++;
         $display("FAIL abort_keep got %h want 1234", rd);
      end
   endtask

   task automatic test_long_frame;
      logic [15:0] rd;
      int ob, eb, w0, f0;
      w0 = n_wr; f0 = n_fe;
      spi_xfer(1'b1, 9'h033, 16'h5A5A, 30, 1'b0, rd, ob, eb);
      n_checks++;
      if (n_wr - w0 != 1 || wr_data !== 16'h5A5A || wr_addr !== 9'h033) begin
         n_errors++;
         $display("FAIL long_write got n=%0d %h/%h want 1 033/5a5a",
                  n_wr - w0, wr_addr, wr_data);
      end
      n_checks++;
      if (eb != 0 || n_fe != f0) begin
         n_errors++;
         $display("FAIL long_extra got bad=%0d fe=%0d want 0/0",
                  eb, n_fe - f0);
      end
      spi_xfer(1'b0, 9'h033, 16'h0000, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (rd !== 16'h5A5A) begin
         n_errors++;
         $display("FAIL long_readback got %h want 5a5a", rd);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] rd;
      int ob, eb, w0, r0, f0, bad;
      spi_xfer(1'b0, 9'h012, 16'h0000, 12, 1'b1, rd, ob, eb);
      #20;
      n_checks++;
      if (spi_miso_oe !== 1'b1 || spi_miso !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_pre got oe=%b miso=%b want 1/1",
                  spi_miso_oe, spi_miso);
      end
      @(posedge sys_clk_50M);
      #1 sys_reset = 1'b1;
      @(posedge sys_clk_50M);
      #1;
      n_checks++;
      if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_release got oe=%b miso=%b want 0/0",
                  spi_miso_oe, spi_miso);
      end
      @(posedge sys_clk_50M);
      #1 sys_reset = 1'b0;
      w0 = n_wr; r0 = n_rd; f0 = n_fe;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         spi_mosi = 1'b1;
         #80 spi_sck = 1'b1;
         #20;
         if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) bad++;
         #60 spi_sck = 1'b0;
      end
      #80 spi_ss_n = 1'b1;
      #300;
      n_checks++;
      if (bad != 0 || n_wr != w0 || n_rd != r0 || n_fe != f0) begin
         n_errors++;
         $display("FAIL rstmid_idle got bad=%0d wr=%0d rd=%0d fe=%0d want 0",
                  bad, n_wr - w0, n_rd - r0, n_fe - f0);
      end
      spi_xfer(1'b0, 9'h012, 16'h0000, 26, 1'b0, rd, ob, eb);
      n_checks++;
      if (rd !== 16'hA5C3 || ob != 0) begin
         n_errors++;
         $display("FAIL rstmid_reread got %h oe_bad=%0d want a5c3/0", rd, ob);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unimpl();
      test_abort();
      test_long_frame();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
